// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals shared by the dmem_arbiter and its neighbours.
// The arbiter takes the slave view, requesters the master view, the data memory the mem view.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  p0_req;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [31:0]           p0_wdata;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    logic [31:0]           p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [31:0]           p1_wdata;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    logic [31:0]           p1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic                  mem_re;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_addr, mem_we, mem_re, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata
    );

    modport mem (
        input  mem_addr, mem_we, mem_re, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port fixed-priority arbiter for a single-port sync-read data memory, port 1 anti-starvation.
// Latency: grant is combinational, read data returns the cycle after the grant.
// Backpressure: a denied request is held by its requester until granted; nothing is queued here.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WAIT   = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic                  p0_gnt;
    logic                  p1_gnt;
    logic [3:0]            wait_q, wait_d;
    logic [1:0]            rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           p0_rdata_q, p0_rdata_d;
    logic [31:0]           p1_rdata_q, p1_rdata_d;

    // Port 0 wins conflicts until port 1 has been denied MAX_WAIT times in a row.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (bus.p0_req && bus.p1_req) begin
                if (wait_q == MAX_W) p1_gnt = 1'b1;
                else                 p0_gnt = 1'b1;
            end else if (bus.p0_req) begin
                p0_gnt = 1'b1;
            end else if (bus.p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_wdata = 32'd0;
        if (p0_gnt) begin
            bus.mem_addr  = bus.p0_addr;
            bus.mem_we    = bus.p0_we;
            bus.mem_re    = ~bus.p0_we;
            bus.mem_wdata = bus.p0_wdata;
        end else if (p1_gnt) begin
            bus.mem_addr  = bus.p1_addr;
            bus.mem_we    = bus.p1_we;
            bus.mem_re    = ~bus.p1_we;
            bus.mem_wdata = bus.p1_wdata;
        end
    end

    always_comb begin
        addr_d   = bus.mem_addr;
        rd_sel_d = {p1_gnt & ~bus.p1_we, p0_gnt & ~bus.p0_we};
        wait_d   = wait_q;
        if (p1_gnt) begin
            wait_d = 4'd0;
        end else if (bus.p1_req && (wait_q != MAX_W)) begin
            wait_d = wait_q + 4'd1;
        end
        p0_rdata_d = rd_sel_q[0] ? bus.mem_rdata : p0_rdata_q;
        p1_rdata_d = rd_sel_q[1] ? bus.mem_rdata : p1_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q     <= 4'd0;
            rd_sel_q   <= 2'b00;
            addr_q     <= '0;
            p0_rdata_q <= 32'd0;
            p1_rdata_q <= 32'd0;
        end else begin
            wait_q     <= wait_d;
            rd_sel_q   <= rd_sel_d;
            addr_q     <= addr_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Returning data bypasses the holding register so it is visible in the valid cycle.
    assign bus.p0_gnt    = p0_gnt;
    assign bus.p1_gnt    = p1_gnt;
    assign bus.p0_rvalid = rd_sel_q[0];
    assign bus.p1_rvalid = rd_sel_q[1];
    assign bus.p0_rdata  = rd_sel_q[0] ? bus.mem_rdata : p0_rdata_q;
    assign bus.p1_rdata  = rd_sel_q[1] ? bus.mem_rdata : p1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: sync-read memory model, arbitration model and per-port read scoreboards.
module tb_dmem_arbiter;
    localparam int AW       = 14;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;

    dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: output register only updates on read cycles.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int            checks = 0;
    int            errors = 0;
    int            mwait  = 0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   ref_mem [int];
    logic [31:0]   exp0 [$];
    logic [31:0]   exp1 [$];

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [31:0] d1);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        advance();
        pre_we = 1'b0;
        ref_mem[int'(a)] = d;
    endtask

    // Mid-cycle check of grants, memory drive and returning reads against the bench model.
    task automatic sample();
        logic          eg0, eg1, ewe, ere;
        logic [AW-1:0] ea;
        logic [31:0]   ewd, d;
        @(negedge clk);
        if (rst) begin
            eg0 = 1'b0; eg1 = 1'b0;
            exp0.delete(); exp1.delete();
            mwait = 0; last_addr = '0;
        end else begin
            eg1 = bus.p1_req && (!bus.p0_req || mwait == MAX_WAIT);
            eg0 = bus.p0_req && !eg1;
        end
        ea  = eg0 ? bus.p0_addr : (eg1 ? bus.p1_addr : last_addr);
        ewe = (eg0 && bus.p0_we) || (eg1 && bus.p1_we);
        ere = (eg0 && !bus.p0_we) || (eg1 && !bus.p1_we);
        ewd = eg0 ? bus.p0_wdata : (eg1 ? bus.p1_wdata : 32'd0);

        checks++;
        if (bus.p0_gnt !== eg0) begin errors++; $display("FAIL p0_gnt got %b expected %b", bus.p0_gnt, eg0); end
        checks++;
        if (bus.p1_gnt !== eg1) begin errors++; $display("FAIL p1_gnt got %b expected %b", bus.p1_gnt, eg1); end
        checks++;
        if (bus.mem_addr !== ea) begin errors++; $display("FAIL mem_addr got %h expected %h", bus.mem_addr, ea); end
        checks++;
        if (bus.mem_we !== ewe || bus.mem_re !== ere) begin
            errors++; $display("FAIL mem_we/re got %b%b expected %b%b", bus.mem_we, bus.mem_re, ewe, ere);
        end
        checks++;
        if (bus.mem_wdata !== ewd) begin errors++; $display("FAIL mem_wdata got %h expected %h", bus.mem_wdata, ewd); end

        checks++;
        if (bus.p0_rvalid !== (exp0.size() != 0)) begin
            errors++; $display("FAIL p0_rvalid got %b expected %b", bus.p0_rvalid, exp0.size() != 0);
        end
        if (exp0.size() != 0) begin
            d = exp0.pop_front();
            checks++;
            if (bus.p0_rdata !== d) begin errors++; $display("FAIL p0_rdata got %h expected %h", bus.p0_rdata, d); end
        end
        checks++;
        if (bus.p1_rvalid !== (exp1.size() != 0)) begin
            errors++; $display("FAIL p1_rvalid got %b expected %b", bus.p1_rvalid, exp1.size() != 0);
        end
        if (exp1.size() != 0) begin
            d = exp1.pop_front();
            checks++;
            if (bus.p1_rdata !== d) begin errors++; $display("FAIL p1_rdata got %h expected %h", bus.p1_rdata, d); end
        end

        if (!rst) begin
            if (eg0 && !bus.p0_we) exp0.push_back(ref_mem[int'(bus.p0_addr)]);
            if (eg0 &&  bus.p0_we) ref_mem[int'(bus.p0_addr)] = bus.p0_wdata;
            if (eg1 && !bus.p1_we) exp1.push_back(ref_mem[int'(bus.p1_addr)]);
            if (eg1 &&  bus.p1_we) ref_mem[int'(bus.p1_addr)] = bus.p1_wdata;
            if (eg0 || eg1) last_addr = ea;
            if (eg1) mwait = 0;
            else if (bus.p1_req && mwait < MAX_WAIT) mwait++;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 14'h0010, 32'd0, 1'b1, 1'b1, 14'h0020, 32'h1111_1111);
        sample();
        checks++;
        if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p0_rdata !== 32'd0 || bus.p1_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got rv %b%b rdata %h %h expected 00 0 0",
                     bus.p1_rvalid, bus.p0_rvalid, bus.p1_rdata, bus.p0_rdata);
        end
        idle();
        advance();
        rst = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_read_p0();
        drive(1'b1, 1'b0, 14'h0010, 32'd0, 1'b0, 1'b0, '0, 32'd0);
        sample();
        advance();
        idle();
        sample();
        checks++;
        if (bus.p0_rdata !== 32'hDEAD_BEEF || bus.p1_rvalid !== 1'b0) begin
            errors++; $display("FAIL read_p0 got %h p1_rvalid %b expected deadbeef 0", bus.p0_rdata, bus.p1_rvalid);
        end
        advance();
    endtask

    task automatic test_write_then_read();
        drive(1'b0, 1'b0, '0, 32'd0, 1'b1, 1'b1, 14'h0020, 32'h1234_5678);
        sample();
        advance();
        drive(1'b1, 1'b0, 14'h0020, 32'd0, 1'b0, 1'b0, '0, 32'd0);
        sample();
        checks++;
        if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
            errors++; $display("FAIL write_no_rvalid got %b%b expected 00", bus.p1_rvalid, bus.p0_rvalid);
        end
        advance();
        idle();
        sample();
        checks++;
        if (bus.p0_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL raw_read got %h expected 12345678", bus.p0_rdata);
        end
        advance();
    endtask

    task automatic test_starvation();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b0, 14'h0010, 32'd0, 1'b1, 1'b0, 14'h0005, 32'd0);
            sample();
            checks++;
            if (bus.p1_gnt !== (k % 5 == 0)) begin
                errors++; $display("FAIL starve cycle %0d p1_gnt got %b expected %b", k, bus.p1_gnt, k % 5 == 0);
            end
            advance();
        end
        idle();
        sample();
        advance();
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b0, '0, 32'd0, 1'b1, 1'b0, 14'h0005, 32'd0);
        sample();
        advance();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(1'b1, 1'b0, 14'h0006, 32'd0, 1'b0, 1'b0, '0, 32'd0);
            else       idle();
            sample();
            checks++;
            if (bus.p1_rdata !== 32'hAAAA_0000) begin
                errors++; $display("FAIL hold cycle %0d p1_rdata got %h expected aaaa0000", k, bus.p1_rdata);
            end
            advance();
        end
        idle();
        sample();
        advance();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 14'h0010, 32'd0, 1'b0, 1'b0, '0, 32'd0);          sample(); advance();
        drive(1'b0, 1'b0, '0, 32'd0, 1'b1, 1'b0, 14'h0006, 32'd0);          sample(); advance();
        drive(1'b1, 1'b0, 14'h0005, 32'd0, 1'b0, 1'b0, '0, 32'd0);          sample(); advance();
        drive(1'b0, 1'b0, '0, 32'd0, 1'b1, 1'b0, 14'h0020, 32'd0);          sample(); advance();
        drive(1'b1, 1'b1, 14'h0033, 32'hCAFE_F00D, 1'b0, 1'b0, '0, 32'd0);  sample(); advance();
        drive(1'b0, 1'b0, '0, 32'd0, 1'b1, 1'b0, 14'h0033, 32'd0);          sample(); advance();
        idle();
        sample();
        checks++;
        if (bus.p1_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_raw p1_rdata got %h expected cafef00d", bus.p1_rdata);
        end
        advance();
    endtask

    task automatic test_idle();
        drive(1'b1, 1'b1, 14'h0044, 32'h0BAD_0BAD, 1'b0, 1'b0, '0, 32'd0);
        sample();
        advance();
        for (int k = 0; k < 3; k++) begin
            idle();
            sample();
            checks++;
            if (bus.mem_addr !== 14'h0044 || bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold addr %h we %b re %b expected 0044 0 0", bus.mem_addr, bus.mem_we, bus.mem_re);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 14'h0010, 32'd0, 1'b0, 1'b0, '0, 32'd0);
        sample();
        advance();
        idle();
        rst = 1'b1;
        sample();
        checks++;
        if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'd0 || bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid rvalid %b rdata %h addr %h expected 0 0 0", bus.p0_rvalid, bus.p0_rdata, bus.mem_addr);
        end
        advance();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            advance();
        end
        drive(1'b0, 1'b0, '0, 32'd0, 1'b1, 1'b0, 14'h0005, 32'd0);
        sample();
        advance();
        idle();
        sample();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = 32'd0;
        idle();
        bus.mem_rdata = 32'd0;
        preload(14'h0010, 32'hDEAD_BEEF);
        preload(14'h0005, 32'hAAAA_0000);
        preload(14'h0006, 32'h5555_FFFF);
        preload(14'h0020, 32'h0000_0000);
        test_reset();
        test_read_p0();
        test_write_then_read();
        test_starvation();
        test_hold();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++; $display("FAIL drain pending %0d %0d expected 0 0", exp0.size(), exp1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
